// File: rtl/player_ctl_multi.sv
// Player cannon controller with a pool of independent bullet slots.
// All game state advances on an internally generated tick strobe.
module player_ctl_multi #(
    parameter int SCREEN_W       = 800,
    parameter int SCREEN_H       = 600,
    parameter int PLAYER_WIDTH   = 32,
    parameter int PLAYER_HEIGHT  = 32,
    parameter int BULLET_WIDTH   = 4,
    parameter int BULLET_HEIGHT  = 16,
    parameter int MOVEMENT_SPEED = 5,
    parameter int BULLET_SPEED   = 3,
    parameter int NUM_BULLETS    = 4,
    parameter int TICK_DIV       = 650000,
    parameter int FIRE_COOLDOWN  = 8,
    parameter int AUTO_FIRE      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      button_left,
    input  logic                      button_right,
    input  logic                      button_shoot,
    input  logic [NUM_BULLETS-1:0]    bullet_hit,
    output logic [11:0]               xpos,
    output logic [12*NUM_BULLETS-1:0] bullet_x,
    output logic [12*NUM_BULLETS-1:0] bullet_y,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic                      shot_fired,
    output logic                      tick
);

    localparam int CW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CDW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    localparam logic [11:0] X_MAX    = 12'(SCREEN_W - PLAYER_WIDTH);
    localparam logic [11:0] X_RST    = 12'((SCREEN_W - PLAYER_WIDTH) / 2);
    localparam logic [11:0] MOVE     = 12'(MOVEMENT_SPEED);
    localparam logic [11:0] BSPD     = 12'(BULLET_SPEED);
    localparam logic [11:0] SPAWN_Y  = 12'(SCREEN_H - PLAYER_HEIGHT - BULLET_HEIGHT);
    localparam logic [11:0] SPAWN_DX = 12'(PLAYER_WIDTH / 2 - BULLET_WIDTH / 2);

    logic [CW-1:0]          tick_cnt;
    logic [CDW-1:0]         cooldown;
    logic [NUM_BULLETS-1:0] hit_pend;
    logic                   shoot_req;
    logic                   shoot_prev;
    logic [11:0]            bx_q [NUM_BULLETS];
    logic [11:0]            by_q [NUM_BULLETS];

    logic                   shoot_rise;
    logic                   fire_req;
    logic                   fire;
    logic                   placed;
    logic [NUM_BULLETS-1:0] kill;
    logic [NUM_BULLETS-1:0] active_d;
    logic [11:0]            bx_d [NUM_BULLETS];
    logic [11:0]            by_d [NUM_BULLETS];
    logic [11:0]            xpos_d;
    logic [CDW-1:0]         cooldown_d;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
        assign bullet_x[12*g +: 12] = bx_q[g];
        assign bullet_y[12*g +: 12] = by_q[g];
    end

    // Next-state values, applied only on the tick edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        shoot_rise = button_shoot & ~shoot_prev;
        fire_req   = (AUTO_FIRE != 0) ? button_shoot : (shoot_req | shoot_rise);
        kill       = hit_pend | bullet_hit;
        active_d   = bullet_active;
        bx_d       = bx_q;
        by_d       = by_q;
        xpos_d     = xpos;
        cooldown_d = cooldown;
        placed     = 1'b0;

        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (bullet_active[i]) begin
                if (kill[i])
                    active_d[i] = 1'b0;
                else if (by_q[i] < BSPD)
                    active_d[i] = 1'b0;
                else
                    by_d[i] = by_q[i] - BSPD;
            end
        end

        // Slots freed this tick are already reusable.
        fire = fire_req && (cooldown == '0) && (~active_d != '0);

        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (fire && !active_d[i] && !placed) begin
                active_d[i] = 1'b1;
                bx_d[i]     = xpos + SPAWN_DX;
                by_d[i]     = SPAWN_Y;
                placed      = 1'b1;
            end
        end

        if (button_left && !button_right)
            xpos_d = (xpos >= MOVE) ? xpos - MOVE : 12'd0;
        else if (button_right && !button_left)
            xpos_d = (xpos + MOVE > X_MAX) ? X_MAX : xpos + MOVE;

        if (fire)
            cooldown_d = CDW'(FIRE_COOLDOWN);
        else if (cooldown != '0)
            cooldown_d = cooldown - CDW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt      <= '0;
            tick          <= 1'b0;
            cooldown      <= '0;
            hit_pend      <= '0;
            shoot_req     <= 1'b0;
            shoot_prev    <= 1'b0;
            xpos          <= X_RST;
            bullet_active <= '0;
            shot_fired    <= 1'b0;
            // NOTE: the slot arrays are a handful of flops, not RAM, so they are reset like any other state.
            for (int i = 0; i < NUM_BULLETS; i++) begin
                bx_q[i] <= '0;
                by_q[i] <= '0;
            end
        end else begin
            tick_cnt   <= (tick_cnt == CW'(TICK_DIV - 1)) ? '0 : tick_cnt + CW'(1);
            tick       <= (tick_cnt == CW'(TICK_DIV - 2));
            shoot_prev <= button_shoot;
            shot_fired <= tick && fire;

            if (tick) begin
                hit_pend      <= '0;
                shoot_req     <= 1'b0;
                xpos          <= xpos_d;
                bullet_active <= active_d;
                bx_q          <= bx_d;
                by_q          <= by_d;
                cooldown      <= cooldown_d;
            end else begin
                hit_pend  <= hit_pend | bullet_hit;
                shoot_req <= (AUTO_FIRE == 0) && (shoot_req | shoot_rise);
            end
        end
    end

endmodule

// File: tb/tb_player_ctl_multi.sv
// Directed bench for player_ctl_multi: movement, firing, cooldown, hits, top exit,
// reset mid-flight, and an auto-fire instance sharing the same tick phase.
module tb_player_ctl_multi;

    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              button_left, button_right, button_shoot;
    logic [NB-1:0]     bullet_hit;
    logic [11:0]       xpos;
    logic [12*NB-1:0]  bullet_x, bullet_y;
    logic [NB-1:0]     bullet_active;
    logic              shot_fired, tick;

    logic              af_shoot;
    logic [11:0]       af_xpos;
    logic [12*NB-1:0]  af_bx, af_by;
    logic [NB-1:0]     af_active;
    logic              af_shot, af_tick;

    int total = 0;
    int bad   = 0;

    player_ctl_multi #(
        .SCREEN_W(640), .SCREEN_H(480), .NUM_BULLETS(NB),
        .TICK_DIV(4), .FIRE_COOLDOWN(2), .AUTO_FIRE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .button_left(button_left), .button_right(button_right),
        .button_shoot(button_shoot), .bullet_hit(bullet_hit),
        .xpos(xpos), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_active(bullet_active), .shot_fired(shot_fired), .tick(tick)
    );

    player_ctl_multi #(
        .SCREEN_W(640), .SCREEN_H(480), .NUM_BULLETS(NB),
        .TICK_DIV(4), .FIRE_COOLDOWN(2), .AUTO_FIRE(1)
    ) dut_af (
        .clk(clk), .rst(rst),
        .button_left(1'b0), .button_right(1'b0),
        .button_shoot(af_shoot), .bullet_hit(2'b00),
        .xpos(af_xpos), .bullet_x(af_bx), .bullet_y(af_by),
        .bullet_active(af_active), .shot_fired(af_shot), .tick(af_tick)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Returns at the negedge just after the next tick edge, once outputs reflect it.
    task automatic step_tick();
        int n = 0;
        while (!tick && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!tick) check("tick_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_shoot();
        button_shoot = 1'b1;
        @(negedge clk);
        button_shoot = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; button_left = 0; button_right = 0; button_shoot = 0;
        bullet_hit = '0; af_shoot = 0;
        repeat (3) @(negedge clk);
        check("rst_xpos", xpos, 304);
        check("rst_active", bullet_active, 0);
        check("rst_tick", tick, 0);
        check("rst_shot", shot_fired, 0);
        check("rst_y", bullet_y, 0);
        rst = 1'b0;

        // Tick period
        n = 0;
        while (!tick && n < 16) begin @(negedge clk); n++; end
        @(negedge clk);
        n = 1;
        while (!tick && n < 16) begin @(negedge clk); n++; end
        check("tick_period", n, 4);
        step_tick();

        // First shot into slot 0
        pulse_shoot();
        step_tick();
        check("shot1_fired", shot_fired, 1);
        check("shot1_active", bullet_active, 2'b01);
        check("shot1_x", bullet_x[11:0], 318);
        check("shot1_y", bullet_y[11:0], 432);
        @(negedge clk);
        check("shot1_pulse_len", shot_fired, 0);

        // Edge on the very next tick is dropped by the cooldown
        pulse_shoot();
        step_tick();
        check("cool_drop_fired", shot_fired, 0);
        check("cool_drop_active", bullet_active, 2'b01);
        step_tick();

        // Edge after the second tick fires on the third, into slot 1
        pulse_shoot();
        step_tick();
        check("shot2_fired", shot_fired, 1);
        check("shot2_active", bullet_active, 2'b11);
        check("shot2_y0", bullet_y[11:0], 423);
        check("shot2_x1", bullet_x[23:12], 318);
        check("shot2_y1", bullet_y[23:12], 432);

        // Both slots busy, cooldown expired: request dropped
        step_tick();
        step_tick();
        pulse_shoot();
        step_tick();
        check("full_fired", shot_fired, 0);
        check("full_active", bullet_active, 2'b11);
        check("full_y0", bullet_y[11:0], 414);
        check("full_y1", bullet_y[23:12], 423);

        // Hit on slot 1 between ticks
        bullet_hit = 2'b10;
        @(negedge clk);
        bullet_hit = 2'b00;
        step_tick();
        check("hit_active", bullet_active, 2'b01);
        check("hit_y0", bullet_y[11:0], 411);
        check("hit_y1_held", bullet_y[23:12], 423);

        pulse_shoot();
        step_tick();
        check("refill_fired", shot_fired, 1);
        check("refill_y1", bullet_y[23:12], 432);
        step_tick();
        step_tick();

        // Hit and new shot resolved on the same tick reuse slot 1
        bullet_hit = 2'b10;
        button_shoot = 1'b1;
        @(negedge clk);
        bullet_hit = 2'b00;
        button_shoot = 1'b0;
        step_tick();
        check("hitfire_fired", shot_fired, 1);
        check("hitfire_active", bullet_active, 2'b11);
        check("hitfire_y1", bullet_y[23:12], 432);
        check("hitfire_y0", bullet_y[11:0], 399);

        // Movement: left to the wall, right to the wall, both held
        button_left = 1'b1;
        repeat (60) step_tick();
        check("left_60", xpos, 4);
        step_tick();
        check("left_61", xpos, 0);
        repeat (9) step_tick();
        check("left_70", xpos, 0);
        button_left = 1'b0;
        button_right = 1'b1;
        step_tick();
        check("right_1", xpos, 5);
        repeat (124) step_tick();
        check("right_sat", xpos, 608);
        button_left = 1'b1;
        repeat (3) step_tick();
        check("both_hold", xpos, 608);
        button_left = 1'b0;
        button_right = 1'b0;

        // Spawn x follows the current cannon position
        pulse_shoot();
        step_tick();
        check("edge_fired", shot_fired, 1);
        check("edge_active", bullet_active, 2'b01);
        check("edge_x0", bullet_x[11:0], 622);

        // Reset mid-flight with a pending request
        pulse_shoot();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_xpos", xpos, 304);
        check("midrst_active", bullet_active, 0);
        check("midrst_shot", shot_fired, 0);
        step_tick();
        check("midrst_no_shot", shot_fired, 0);
        check("midrst_still_idle", bullet_active, 0);

        // Top exit: 432 -> 3 -> 0 -> freed without wrapping
        pulse_shoot();
        step_tick();
        check("top_spawn", bullet_y[11:0], 432);
        repeat (143) step_tick();
        check("top_y3", bullet_y[11:0], 3);
        check("top_y3_active", bullet_active, 2'b01);
        step_tick();
        check("top_y0", bullet_y[11:0], 0);
        check("top_y0_active", bullet_active, 2'b01);
        step_tick();
        check("top_exit_active", bullet_active, 0);
        check("top_exit_y", bullet_y[11:0], 0);

        // Auto-fire: held button fires every third tick while a slot is free
        af_shoot = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step_tick();
            check($sformatf("af_tick%0d", k), af_shot, (k == 1 || k == 4) ? 1 : 0);
        end
        check("af_active", af_active, 2'b11);
        af_shoot = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
